// File: rtl/led_trail_fader.sv
// LED trail fader: every LED lit by the bouncer jumps to full brightness and
// then fades out in fixed steps, giving a comet tail behind the moving LED.
// Brightness is rendered with a shared free-running PWM counter. With enable
// low the block is a plain two-stage register from pos_in to led_out.
module led_trail_fader #(
  parameter int N_LEDS     = 10,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 500000,
  parameter int DECAY_STEP = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_LEDS-1:0] pos_in,
  output logic [N_LEDS-1:0] led_out
);

  // A one-cycle decay interval still needs a one-bit counter.
  localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX_B    = '1;
  localparam logic [PWM_BITS-1:0] STEP_B   = PWM_BITS'(DECAY_STEP);
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);

  logic [N_LEDS-1:0]   pos_q;
  logic [PWM_BITS-1:0] b     [N_LEDS];
  logic [PWM_BITS-1:0] b_nxt [N_LEDS];
  logic [N_LEDS-1:0]   led_nxt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;

  // Single input register; the bouncer output is already on this clock.
  always_ff @(posedge clk) begin
    if (reset) pos_q <= '0;
    else       pos_q <= pos_in;
  end

  // Decay prescaler; tick is a registered one-cycle pulse at the wrap point.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (pre_cnt == PRE_LAST);
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // PWM ramp runs only in fade mode and freezes in bypass.
  always_ff @(posedge clk) begin
    if (reset)       pwm_cnt <= '0;
    else if (enable) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Per-LED brightness and output: load beats decay, decay saturates at 0.
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) begin
      b_nxt[i]   = b[i];
      led_nxt[i] = pos_q[i];
      if (!enable) begin
        b_nxt[i] = '0;
      end else begin
        led_nxt[i] = (b[i] == MAX_B) || (b[i] > pwm_cnt);
        if (pos_q[i])
          b_nxt[i] = MAX_B;
        else if (tick)
          b_nxt[i] = (b[i] > STEP_B) ? b[i] - STEP_B : '0;
      end
    end
  end

  // Brightness and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_LEDS; i++) b[i] <= '0;
      led_out <= '0;
    end else begin
      b       <= b_nxt;
      led_out <= led_nxt;
    end
  end

endmodule

// File: doc/led_trail_fader.md
Name: led_trail_fader

Overview:
- Downstream stage of the LED bouncer. Consumes its 10-bit LED position vector and drives the physical LEDs.
- Every LED the bouncer lights goes to full brightness, then fades out in steps via per-LED PWM. The result is a "comet tail" behind the moving LED.
- Single clock domain: the bouncer's divided-clock output is sampled on the board clock.

Parameters:
- N_LEDS, 10, number of LEDs / width of position vector
- PWM_BITS, 8, brightness resolution; MAX = 2^PWM_BITS-1
- DECAY_DIV, 500000, clk cycles between decay steps (>=1)
- DECAY_STEP, 32, brightness removed per decay step (1..MAX)

Ports:
- clk  in  1  board clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = fade mode, 0 = bypass mode
- pos_in  in  N_LEDS  LED vector from bouncer; any bit pattern legal
- led_out  out  N_LEDS  registered PWM drive to LEDs

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset (sampled on posedge clk) clears the following to 0: pos_q, all b[i], pwm_cnt, pre_cnt, tick, led_out.
  - Reset mid-fade aborts all fades; there is no residual glow after release.
- Input stage: pos_q <= pos_in every cycle, including when enable=0. No other synchronisation.
- Prescaler, when enable=1:
  - pre_cnt counts 0..DECAY_DIV-1 and wraps.
  - tick <= (pre_cnt == DECAY_DIV-1), registered, so it is a 1-cycle pulse.
  - With DECAY_DIV=1, tick is 1 every cycle.
- PWM counter: pwm_cnt is PWM_BITS wide, increments every cycle when enable=1, and wraps MAX->0.
- Brightness update, per LED i, when enable=1, with this priority:
  - pos_q[i]==1 -> b[i] <= MAX. Load beats decay when it coincides with tick.
  - else tick==1 -> b[i] <= (b[i] > DECAY_STEP) ? b[i]-DECAY_STEP : 0. Saturating; never wraps.
  - else hold.
- Output, when enable=1: led_out[i] <= (b[i]==MAX) | (b[i] > pwm_cnt).
  - b=MAX gives constant on.
  - b=0 gives constant off.
  - Otherwise duty is exactly b/2^PWM_BITS over any 2^PWM_BITS consecutive cycles with constant b.
- Bypass, when enable=0:
  - led_out <= pos_q.
  - All b[i] <= 0.
  - pre_cnt <= 0, tick <= 0; pwm_cnt holds.
- Enable edges:
  - Re-enabling starts with b=0 (except bits being loaded) and the prescaler at 0. The first tick comes DECAY_DIV+1 cycles after enable rises.
  - Disabling clears trails on the next edge.
- Latency:
  - enable=1: a rising pos_in bit gives led_out=1 on the 3rd posedge (pos_in->pos_q->b->led_out).
  - enable=0: 2 posedges.
- Trail length: a bit released at b=MAX reaches 0 after ceil(MAX/DECAY_STEP) ticks and stays 0.
- Independence: bits are independent. Several simultaneous high bits each hold MAX.

Test Plan:
- Reset test:
  - Stimulus: enable=1, pos_in=10'h3FF, reset held 3 cycles.
  - Required: led_out=0 throughout and on the first cycle after release; led_out=10'h3FF from the 3rd posedge after release.
- Latency and steady-on test:
  - Stimulus: enable=1, pos_in=10'h001 applied at edge 0 and held.
  - Required: led_out[0]=0 at edges 1-2 and 1 at every edge from 3 on; led_out[9:1]=0.
- Fade duty test:
  - Setup: DECAY_DIV=1024, DECAY_STEP=64.
  - Stimulus: pulse pos_in[2] for 1 cycle.
  - Required: count of led_out[2]=1 over a 256-cycle window wholly inside the first decay interval = 256 (MAX path); after tick 1 = 191; after tick 2 = 127; after tick 3 = 63; after tick 4 and forever = 0.
- Saturation test:
  - Setup: DECAY_STEP=100.
  - Required: b sequence 255, 155, 55, 0, 0 with no wrap; led_out[2] stays 0 after the 3rd tick.
- Collision test:
  - Setup: DECAY_DIV=4.
  - Stimulus: assert pos_q[5] on the exact cycle tick=1.
  - Required: b[5]=255, not 223; led_out[5] is constant 1 while held.
- Bypass test:
  - Stimulus: enable=0, pos_in walks 10'h001->10'h002->10'h004, one per cycle.
  - Required: led_out follows with 2-cycle latency with no trail; pwm_cnt frozen.
  - Then set enable=1: the first tick occurs DECAY_DIV+1 cycles later.
